// File: rtl/bin_to_bcd_if.sv
// Handshake bundle for bin_to_bcd: binary word in, packed BCD digits plus sign out.
// The master side is the producer of words and the consumer of results.
interface bin_to_bcd_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic                  neg;

    modport master (
        output in_valid, bin, out_ready,
        input  in_ready, out_valid, bcd, neg
    );

    modport slave (
        input  in_valid, bin, out_ready,
        output in_ready, out_valid, bcd, neg
    );
endinterface

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional macro BIN_TO_BCD_SIGNED_EN: treat bin as two's complement and report the sign on neg.
//
// state   | meaning
// S_IDLE  | ready for a word; bcd/neg hold the previous result
// S_SHIFT | one add-3/shift iteration per cycle, WIDTH iterations in total
// S_DONE  | result presented until out_ready
module bin_to_bcd #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic          clk,
    input  logic          rst,
    bin_to_bcd_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int DW = 4 * DIGITS;

    function automatic bit f_digits_ok();
        longint unsigned p;
        longint unsigned lim;
        p = 64'd1;
`ifdef BIN_TO_BCD_SIGNED_EN
        lim = 64'd1 << (WIDTH - 1);
`else
        lim = (64'd1 << WIDTH) - 64'd1;
`endif
        if (DIGITS >= 19) return 1'b1;
        for (int i = 0; i < DIGITS; i++) p = p * 64'd10;
        return p > lim;
    endfunction

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("bin_to_bcd: WIDTH must be in 2..32");
        end
        if (DIGITS < 1 || !f_digits_ok()) begin : g_bad_digits
            $error("bin_to_bcd: DIGITS too small for WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nxt;
    logic [CW-1:0]       r_cnt;
    logic [WIDTH-1:0]    r_bin;
    logic [DW-1:0]       r_dig;
    logic                r_sign;
    logic [DW-1:0]       r_bcd;
    logic                r_neg;
    logic                r_in_ready;
    logic                r_out_valid;

    logic                w_last;
    logic [DW-1:0]       w_adj;
    logic [DW+WIDTH-1:0] w_cat;
    logic [WIDTH-1:0]    w_mag;
    logic                w_sign;

    assign w_last = (r_cnt == CW'(WIDTH - 1));

`ifdef BIN_TO_BCD_SIGNED_EN
    // Negating the most negative value wraps to itself, which read as unsigned is the right magnitude.
    assign w_sign = bus.bin[WIDTH-1];
    assign w_mag  = w_sign ? -bus.bin : bus.bin;
`else
    assign w_sign = 1'b0;
    assign w_mag  = bus.bin;
`endif

    always_comb begin
        w_adj = r_dig;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_dig[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_dig[4*d +: 4] + 4'd3;
        end
    end

    assign w_cat = {w_adj, r_bin} << 1;

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_nxt = S_SHIFT;
            S_SHIFT: if (w_last)        w_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_nxt = S_IDLE;
            default:                    w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            r_in_ready  <= (w_nxt == S_IDLE);
            r_out_valid <= (w_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_bin  <= '0;
            r_dig  <= '0;
            r_sign <= 1'b0;
            r_bcd  <= '0;
            r_neg  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_bin  <= w_mag;
                        r_dig  <= '0;
                        r_cnt  <= '0;
                        r_sign <= w_sign;
                    end
                end
                S_SHIFT: begin
                    r_dig <= w_cat[DW+WIDTH-1:WIDTH];
                    r_bin <= w_cat[WIDTH-1:0];
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_bcd <= w_cat[DW+WIDTH-1:WIDTH];
                        r_neg <= r_sign;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.bcd       = r_bcd;
    assign bus.neg       = r_neg;
endmodule

// File: tb/tb_bin_to_bcd.sv
// Scoreboard bench for bin_to_bcd: stimulus pushes expected results, a monitor pops and compares.
module tb_bin_to_bcd;
    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int DW     = 4 * DIGITS;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    logic [DW:0]   exp_q[$];
    int            t_q[$];
    logic [DW:0]   held = '0;
    logic          prev_ov = 1'b0;

    bin_to_bcd_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bin_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [DW:0] model(input logic [WIDTH-1:0] v);
        longint   m;
        logic     n;
        logic [DW-1:0] r;
        m = longint'(v);
        n = 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
        if (v[WIDTH-1]) begin
            n = 1'b1;
            m = (longint'(1) << WIDTH) - longint'(v);
        end
`endif
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return {n, r};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: results are checked as out_valid rises; held results must stay put.
    initial begin
        logic [DW:0] e;
        int          t;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov = 1'b0;
                held    = '0;
            end else begin
                if (bus.out_valid && !prev_ov) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        t = t_q.pop_front();
                        chk("result", 64'({bus.neg, bus.bcd}), 64'(e));
                        chk("latency", 64'(cyc - t), 64'(WIDTH + 1));
                    end
                    held = {bus.neg, bus.bcd};
                end else begin
                    chk("hold", 64'({bus.neg, bus.bcd}), 64'(held));
                end
                prev_ov = bus.out_valid;
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] v);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", 64'(0), 64'(1));
            return;
        end
        bus.in_valid = 1'b1;
        bus.bin      = v;
        exp_q.push_back(model(v));
        t_q.push_back(cyc);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.bin      = WIDTH'($urandom);
    endtask

    task automatic wait_ov();
        int n;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) chk("out_valid_timeout", 64'(0), 64'(1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || bus.out_valid) chk("drain_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        logic [DW:0] e;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.bin       = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_bcd", 64'(bus.bcd), 64'(0));
        chk("rst_neg", 64'(bus.neg), 64'(0));
        rst = 1'b0;

        send(8'd255);
        drain();

        // Back-to-back accepts with out_ready held high.
        send(8'd0);
        send(8'd99);
        send(8'd100);
        drain();

        // Backpressure on a finished result.
        bus.out_ready = 1'b0;
        send(8'd173);
        e = model(8'd173);
        wait_ov();
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 64'(bus.out_valid), 64'(1));
            chk("bp_bcd", 64'({bus.neg, bus.bcd}), 64'(e));
            chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 64'(bus.in_ready), 64'(1));
        chk("bp_release_out_valid", 64'(bus.out_valid), 64'(0));
        drain();

        // in_valid mid-SHIFT must be ignored.
        send(8'd200);
        @(negedge clk);
        chk("shift_in_ready", 64'(bus.in_ready), 64'(0));
        bus.in_valid = 1'b1;
        bus.bin      = 8'd42;
        @(negedge clk);
        bus.in_valid = 1'b0;
        drain();
        repeat (15) @(negedge clk);

        // Asynchronous reset in the middle of a conversion.
        send(8'd255);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        t_q.delete();
        #1;
        chk("abort_out_valid", 64'(bus.out_valid), 64'(0));
        chk("abort_in_ready", 64'(bus.in_ready), 64'(1));
        chk("abort_bcd", 64'(bus.bcd), 64'(0));
        @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        send(8'd9);
        drain();

        send(8'h80);
        send(8'hFF);
        send(8'h7F);
        drain();

        for (int i = 0; i < 30; i++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            send(WIDTH'($urandom));
            if (!bus.out_ready) begin
                wait_ov();
                repeat ($urandom_range(0, 3)) @(negedge clk);
                bus.out_ready = 1'b1;
            end
            drain();
        end

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bin_to_bcd.md
# bin_to_bcd

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. Processes one bit per clock.
- Input: a WIDTH-bit binary word.
- Output: DIGITS packed 4-bit BCD digits, each 0–9.
- Sits directly upstream of the BCD adder and feeds it operand digits in the same 4-bit BCD digit format.
- Valid/ready handshakes on both sides; one conversion in flight at a time.

## Interface
- WIDTH, 8, binary input width; legal range 2–32.
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH − 1; otherwise elaboration fails with $error.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  bin holds a word to convert.
- in_ready  output  1  converter can accept a word; high only in IDLE.
- bin  input  WIDTH  binary operand; sampled only on the accept edge.
- out_valid  output  1  bcd/neg hold a finished result.
- out_ready  input  1  downstream consumes the result.
- bcd  output  4*DIGITS  result; bcd[3:0] is the least-significant digit, bcd[4*DIGITS-1 -: 4] the most-significant.
- neg  output  1  sign of the result; see Configuration.

## Operation
- States:
  - IDLE: in_ready=1. When in_valid=1, capture bin into the shift register, clear the digit register and the bit counter, and go to SHIFT.
  - SHIFT: in_ready=0, out_valid=0. Each cycle performs one iteration:
    - Every digit ≥ 5 gets +3 (4-bit add, no carry between digits).
    - The concatenation {digits, binary} shifts left by 1; the binary MSB enters digit-0 bit 0.
    - The counter increments.
    - After the WIDTH-th iteration, load bcd/neg and go to DONE.
  - DONE: out_valid=1; bcd/neg held stable. When out_ready=1, go to IDLE.
- Digit arithmetic: a digit is never ≥ 10 before adjustment. Every output digit is 0–9.
- in_valid outside IDLE is ignored. The word is not queued and in_ready stays 0.
- out_ready outside DONE is ignored.
- bin may change freely after the accept edge.
- Reset, at any time including mid-SHIFT or in DONE:
  - Immediately aborts.
  - State goes to IDLE.
  - Outputs take their reset values: bcd=0, neg=0, out_valid=0, in_ready=1.
  - The counter and shift register clear.

## Timing
- Handshake: a transfer occurs on a rising edge where valid & ready are both 1.
- Accept edge A (in_valid & in_ready) → out_valid rises after edge A+WIDTH. Latency is WIDTH cycles, independent of value.
- Output transfer edge D (out_valid & out_ready) → in_ready=1 after edge D. The next accept is at D+1 at the earliest.
- Peak throughput: one word per WIDTH+2 cycles.
- All outputs are registered; no combinational path from input to output.
- bcd and neg change only on the edge that enters DONE, or on reset. They hold their value in IDLE until the next result.

## Configuration
- Macro: BIN_TO_BCD_SIGNED_EN.
- Defined:
  - bin is two's complement.
  - On accept, neg = bin[WIDTH-1] and the register loads |bin|.
  - −2^(WIDTH-1) converts correctly: the magnitude is treated as unsigned WIDTH bits.
  - The DIGITS legality check uses 2^(WIDTH-1).
- Undefined:
  - bin is unsigned.
  - neg is constant 0.
  - The port still exists.

## Test plan
- Unsigned, WIDTH=8, DIGITS=3: accept 255 → exactly 8 cycles later out_valid=1, bcd=0x255, neg=0.
- Accept 0 → bcd=0x000. Then accept 99 → bcd=0x099. Then accept 100 → bcd=0x100. out_ready is held 1 throughout and accepts are back-to-back, spaced 10 cycles.
- Backpressure: result 173 with out_ready=0 for 5 cycles → out_valid and bcd=0x173 stable all 5 cycles; in_ready=0. out_ready=1 → next cycle IDLE, in_ready=1.
- in_valid pulsed with 42 mid-SHIFT of 200 → ignored. Output is 0x200, and no second result appears.
- rst asserted asynchronously at iteration 4 of converting 255 → immediately out_valid=0, in_ready=1, bcd=0. The next conversion of 9 yields 0x009.
- BIN_TO_BCD_SIGNED_EN defined: 0x80 → neg=1, bcd=0x128; 0xFF → neg=1, bcd=0x001; 0x7F → neg=0, bcd=0x127.
